// File: rtl/axi_mem_responder_pkg.sv
// Shared types and helpers for the AXI4 on-chip memory responder.
package axi_mem_responder_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 64;
  localparam int unsigned DataW = 64;
  localparam int unsigned StrbW = DataW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    WRESP = 2'd3
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } m_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } m_resp_t;

  // Byte lanes touched by a beat of 2^size bytes at the given address low bits.
  function automatic logic [StrbW-1:0] lane_mask(input logic [2:0] addr_lo,
                                                 input logic [2:0] size);
    logic [3:0]       nbytes;
    logic [2:0]       base;
    logic [StrbW-1:0] m;
    if (size > 3'd3) begin
      return '1;
    end
    nbytes = 4'd1 << size;
    base   = addr_lo & ~(3'(nbytes - 4'd1));
    m      = 8'((16'd1 << nbytes) - 16'd1);
    return m << base;
  endfunction

endpackage

// File: rtl/axi_mem_responder_addr_gen.sv
// Combinational beat-address generator with window and burst-support checks.
module axi_burst_addr_gen
  import axi_mem_responder_pkg::*;
#(
  parameter logic [63:0] BaseAddr  = 64'h8000_0000,
  parameter int unsigned MemBytes  = 65536,
  parameter int unsigned DataBytes = 8
) (
  input  logic [63:0] start_addr_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  input  logic [7:0]  beat_idx_i,
  output logic [63:0] beat_addr_o,
  output logic        in_range_o,
  output logic        supported_o
);

  localparam logic [2:0]  MaxSize = 3'($clog2(DataBytes));
  localparam logic [63:0] EndAddr = BaseAddr + 64'(MemBytes);

  logic [63:0] aligned;
  logic [63:0] offset;

  function automatic logic in_win(input logic [63:0] a);
    return (a >= BaseAddr) && (a < EndAddr);
  endfunction

  // FIXED repeats the start address; INCR steps from the size-aligned start.
  always_comb begin
    aligned     = start_addr_i & ~((64'd1 << size_i) - 64'd1);
    offset      = 64'(beat_idx_i) << size_i;
    beat_addr_o = (burst_i == BURST_FIXED) ? start_addr_i : (aligned + offset);
    in_range_o  = in_win(start_addr_i) && in_win(beat_addr_o);
    supported_o = ((burst_i == BURST_FIXED) || (burst_i == BURST_INCR)) &&
                  (size_i <= MaxSize);
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate serving one transaction at a time from an on-chip SRAM.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter logic [63:0] BaseAddr  = 64'h8000_0000,
  parameter int unsigned MemBytes  = 65536,
  parameter int unsigned DataBytes = 8
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  m_req_t  axi_req_i,
  output m_resp_t axi_resp_o
);

  localparam int unsigned Words  = MemBytes / DataBytes;
  localparam int unsigned WordW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned OffLsb = $clog2(DataBytes);

  state_e           state_q, state_d;
  logic             wr_prio_q, wr_prio_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [63:0]      addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       burst_q, burst_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             wlerr_q, wlerr_d;
  logic             r_valid_q, r_valid_d;
  logic [DataW-1:0] r_data_q, r_data_d;
  logic [1:0]       r_resp_q, r_resp_d;
  logic             r_last_q, r_last_d;
  logic [1:0]       b_resp_q, b_resp_d;

  logic             aw_ready, ar_ready, w_ready;
  logic             grant_wr, grant_rd;
  ax_chan_t         chk_ax;
  logic [63:0]      chk_addr_unused;
  logic             chk_in_range, chk_supported;
  logic [63:0]      beat_addr;
  logic             beat_range_unused, beat_sup_unused;
  logic [WordW-1:0] widx;
  logic [DataW-1:0] rd_word;
  logic             mem_we;
  logic [StrbW-1:0] mem_be;
  logic             beat_last, wl_bad;

  logic [DataW-1:0] mem [Words];

  function automatic logic [1:0] classify(input logic in_range, input logic supported);
    if (!in_range) begin
      return RESP_DECERR;
    end
    if (!supported) begin
      return RESP_SLVERR;
    end
    return RESP_OKAY;
  endfunction

  // With both valids high the pointer picks; a lone valid always wins.
  assign grant_wr = axi_req_i.aw_valid && (!axi_req_i.ar_valid || wr_prio_q);
  assign grant_rd = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !wr_prio_q);
  assign chk_ax   = grant_wr ? axi_req_i.aw : axi_req_i.ar;

  // Checking the final beat at accept time covers the whole burst, so an
  // out-of-window burst never touches the SRAM.
  axi_burst_addr_gen #(
    .BaseAddr (BaseAddr),
    .MemBytes (MemBytes),
    .DataBytes(DataBytes)
  ) u_chk_gen (
    .start_addr_i(chk_ax.addr),
    .size_i      (chk_ax.size),
    .burst_i     (chk_ax.burst),
    .beat_idx_i  (chk_ax.len),
    .beat_addr_o (chk_addr_unused),
    .in_range_o  (chk_in_range),
    .supported_o (chk_supported)
  );

  axi_burst_addr_gen #(
    .BaseAddr (BaseAddr),
    .MemBytes (MemBytes),
    .DataBytes(DataBytes)
  ) u_beat_gen (
    .start_addr_i(addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .beat_idx_i  (cnt_q),
    .beat_addr_o (beat_addr),
    .in_range_o  (beat_range_unused),
    .supported_o (beat_sup_unused)
  );

  assign widx    = WordW'((beat_addr - BaseAddr) >> OffLsb);
  assign rd_word = mem[widx];

  // Next-state, handshake and beat sequencing for the single active transaction.
  always_comb begin
    state_d   = state_q;
    wr_prio_d = wr_prio_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wlerr_d   = wlerr_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    b_resp_d  = b_resp_q;
    aw_ready  = 1'b0;
    ar_ready  = 1'b0;
    w_ready   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    beat_last = (cnt_q == len_q);
    wl_bad    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_wr || grant_rd) begin
          aw_ready  = grant_wr;
          ar_ready  = grant_rd;
          id_d      = chk_ax.id;
          addr_d    = chk_ax.addr;
          len_d     = chk_ax.len;
          size_d    = chk_ax.size;
          burst_d   = chk_ax.burst;
          cnt_d     = 8'd0;
          err_d     = classify(chk_in_range, chk_supported);
          wlerr_d   = 1'b0;
          wr_prio_d = ~wr_prio_q;
          state_d   = grant_wr ? WR : RD;
        end
      end

      RD: begin
        // Fetch a beat on entry and after each non-final handshake; otherwise
        // the presented beat is held.
        if (!r_valid_q || (axi_req_i.r_ready && !r_last_q)) begin
          r_valid_d = 1'b1;
          r_data_d  = (err_q == RESP_OKAY) ? rd_word : '0;
          r_resp_d  = err_q;
          r_last_d  = beat_last;
          if (!beat_last) begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (axi_req_i.r_ready) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
          state_d   = IDLE;
        end
      end

      WR: begin
        w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          if (err_q == RESP_OKAY) begin
            mem_we = 1'b1;
            mem_be = axi_req_i.w.strb & lane_mask(beat_addr[2:0], size_q);
          end
          wl_bad = (axi_req_i.w.last != beat_last);
          if (beat_last) begin
            b_resp_d = (err_q != RESP_OKAY) ? err_q :
                       (wlerr_q || wl_bad)  ? RESP_SLVERR : RESP_OKAY;
            state_d  = WRESP;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            wlerr_d = wlerr_q || wl_bad;
          end
        end
      end

      WRESP: begin
        if (axi_req_i.b_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset aborts any transaction silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_prio_q <= 1'b1;
      id_q      <= '0;
      cnt_q     <= 8'd0;
      err_q     <= RESP_OKAY;
      wlerr_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      wr_prio_q <= wr_prio_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wlerr_q   <= wlerr_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Latched request fields only matter while a transaction is active.
  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    len_q   <= len_d;
    size_q  <= size_d;
    burst_q <= burst_d;
  end

  // SRAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      for (int b = 0; b < StrbW; b++) begin
        if (mem_be[b]) begin
          mem[widx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
        end
      end
    end
  end

  // Readies are masked during reset so no handshake completes in that cycle.
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready && !rst_i;
    axi_resp_o.ar_ready = ar_ready && !rst_i;
    axi_resp_o.w_ready  = w_ready && !rst_i;
    axi_resp_o.b_valid  = (state_q == WRESP);
    axi_resp_o.b.id     = id_q;
    axi_resp_o.b.resp   = b_resp_q;
    axi_resp_o.r_valid  = r_valid_q;
    axi_resp_o.r.id     = id_q;
    axi_resp_o.r.data   = r_data_q;
    axi_resp_o.r.resp   = r_resp_q;
    axi_resp_o.r.last   = r_last_q;
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder.
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  logic    clk;
  logic    rst;
  m_req_t  req;
  m_resp_t resp;

  int n_chk;
  int n_fail;

  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  int          rd_beats;
  int          rd_lat;

  axi_mem_responder dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .axi_req_i (req),
    .axi_resp_o(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ax_chan_t mk_ax(input logic [3:0] id, input logic [63:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    ax_chan_t a;
    a.id    = id;
    a.addr  = addr;
    a.len   = len;
    a.size  = size;
    a.burst = burst;
    return a;
  endfunction

  task automatic do_write(input string tag, input logic [3:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [63:0] d0,
                          input logic [7:0] strb, input int last_at,
                          input logic [1:0] exp_resp);
    int n;
    req.aw       = mk_ax(id, addr, len, size, burst);
    req.aw_valid = 1'b1;
    #1;
    n = 0;
    while (!resp.aw_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_aw_ready"}, 64'(resp.aw_ready), 64'd1);
    tick();
    req.aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      req.w_valid = 1'b1;
      req.w.data  = d0 + 64'(k);
      req.w.strb  = strb;
      req.w.last  = (k == last_at);
      #1;
      chk({tag, "_w_ready"}, 64'(resp.w_ready), 64'd1);
      tick();
    end
    req.w_valid = 1'b0;
    req.w.last  = 1'b0;
    req.b_ready = 1'b1;
    #1;
    n = 0;
    while (!resp.b_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_b_valid"}, 64'(resp.b_valid), 64'd1);
    chk({tag, "_b_resp"}, 64'(resp.b.resp), 64'(exp_resp));
    chk({tag, "_b_id"}, 64'(resp.b.id), 64'(id));
    tick();
    req.b_ready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, input bit stall);
    int          n;
    bit          have_snap;
    logic [63:0] snap_d;
    logic [2:0]  snap_c;
    req.ar       = mk_ax(id, addr, len, 3'd3, burst);
    req.ar_valid = 1'b1;
    #1;
    n = 0;
    while (!resp.ar_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ar_ready"}, 64'(resp.ar_ready), 64'd1);
    tick();
    req.ar_valid = 1'b0;
    rd_beats  = 0;
    rd_lat    = -1;
    have_snap = 1'b0;
    for (int cyc = 0; cyc < 200 && rd_beats <= int'(len); cyc++) begin
      req.r_ready = stall ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (have_snap) begin
        chk({tag, "_hold_data"}, resp.r.data, snap_d);
        chk({tag, "_hold_ctl"}, 64'({resp.r_valid, resp.r.resp}), 64'(snap_c));
        have_snap = 1'b0;
      end
      if (resp.r_valid) begin
        if (rd_lat < 0) rd_lat = cyc + 1;
        if (req.r_ready) begin
          if (rd_beats < 16) begin
            rd_data[rd_beats] = resp.r.data;
            rd_resp[rd_beats] = resp.r.resp;
            rd_last[rd_beats] = resp.r.last;
          end
          rd_id = resp.r.id;
          rd_beats++;
        end else begin
          snap_d    = resp.r.data;
          snap_c    = {resp.r_valid, resp.r.resp};
          have_snap = 1'b1;
        end
      end
      tick();
    end
    req.r_ready = 1'b0;
    chk({tag, "_beats"}, 64'(rd_beats), 64'(int'(len) + 1));
    #1;
    chk({tag, "_r_valid_after"}, 64'(resp.r_valid), 64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    req    = '0;
    rst    = 1'b1;
    tick();
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    tick();
    #1;
    chk("reset_handshakes", 64'({resp.aw_ready, resp.ar_ready, resp.w_ready,
                                 resp.b_valid, resp.r_valid}), 64'd0);
    chk("reset_fields", 64'({resp.b, resp.r.id, resp.r.resp, resp.r.last}), 64'd0);
    chk("reset_rdata", resp.r.data, 64'd0);
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // single-beat write then read; first r_valid two cycles after AR handshake
    do_write("pre", 4'd1, 64'h8000_0010, 8'd0, 3'd3, BURST_INCR,
             64'h1122_3344_5566_7788, 8'hFF, 0, RESP_OKAY);
    do_read("single", 4'd2, 64'h8000_0010, 8'd0, BURST_INCR, 1'b0);
    chk("single_lat", 64'(rd_lat), 64'd2);
    chk("single_data", rd_data[0], 64'h1122_3344_5566_7788);
    chk("single_resp", 64'(rd_resp[0]), 64'(RESP_OKAY));
    chk("single_last", 64'(rd_last[0]), 64'd1);
    chk("single_id", 64'(rd_id), 64'd2);

    // INCR burst with stalled read-back
    do_write("incr_wr", 4'd5, 64'h8000_0100, 8'd3, 3'd3, BURST_INCR,
             64'hA0, 8'hFF, 3, RESP_OKAY);
    do_read("incr_rd", 4'd5, 64'h8000_0100, 8'd3, BURST_INCR, 1'b1);
    chk("incr_lat", 64'(rd_lat), 64'd2);
    chk("incr_d0", rd_data[0], 64'hA0);
    chk("incr_d1", rd_data[1], 64'hA1);
    chk("incr_d2", rd_data[2], 64'hA2);
    chk("incr_d3", rd_data[3], 64'hA3);
    chk("incr_last", 64'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 64'b0001);

    // narrow byte write only changes lane 3
    do_write("nar_pre", 4'd1, 64'h8000_0200, 8'd0, 3'd3, BURST_INCR,
             64'h0807_0605_0403_0201, 8'hFF, 0, RESP_OKAY);
    do_write("nar_wr", 4'd1, 64'h8000_0203, 8'd0, 3'd0, BURST_INCR,
             64'hFFEE_DDCC_BBAA_9988, 8'hFF, 0, RESP_OKAY);
    do_read("nar_rd", 4'd1, 64'h8000_0200, 8'd0, BURST_INCR, 1'b0);
    chk("nar_data", rd_data[0], 64'h0807_0605_BB03_0201);

    // decode errors: read below window, write above window
    do_write("dec_pre", 4'd1, 64'h8000_0000, 8'd0, 3'd3, BURST_INCR,
             64'hCAFE_F00D_1234_5678, 8'hFF, 0, RESP_OKAY);
    do_read("dec_rd", 4'd3, 64'h7FFF_FFF8, 8'd1, BURST_INCR, 1'b0);
    chk("dec_rd_d0", rd_data[0], 64'd0);
    chk("dec_rd_d1", rd_data[1], 64'd0);
    chk("dec_rd_resp", 64'({rd_resp[0], rd_resp[1]}), 64'({RESP_DECERR, RESP_DECERR}));
    chk("dec_rd_last", 64'({rd_last[0], rd_last[1]}), 64'b01);
    do_write("dec_wr", 4'd4, 64'h8001_0000, 8'd0, 3'd3, BURST_INCR,
             64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, RESP_DECERR);
    do_read("dec_chk", 4'd1, 64'h8000_0000, 8'd0, BURST_INCR, 1'b0);
    chk("dec_sram_kept", rd_data[0], 64'hCAFE_F00D_1234_5678);

    // unsupported burst and misplaced w_last
    do_write("wrap", 4'd7, 64'h8000_0400, 8'd3, 3'd3, BURST_WRAP,
             64'h77, 8'hFF, 3, RESP_SLVERR);
    do_write("early_last", 4'd2, 64'h8000_0410, 8'd1, 3'd3, BURST_INCR,
             64'h88, 8'hFF, 0, RESP_SLVERR);

    // arbitration from a fresh reset: write first, then read
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req.aw       = mk_ax(4'd3, 64'h8000_0300, 8'd0, 3'd3, BURST_INCR);
    req.ar       = mk_ax(4'd4, 64'h8000_0300, 8'd0, 3'd3, BURST_INCR);
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    #1;
    chk("arb1_grant", 64'({resp.aw_ready, resp.ar_ready}), 64'b10);
    tick();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b1;
    req.w.data   = 64'h55;
    req.w.strb   = 8'hFF;
    req.w.last   = 1'b1;
    tick();
    req.w_valid  = 1'b0;
    req.w.last   = 1'b0;
    req.b_ready  = 1'b1;
    req.aw       = mk_ax(4'd6, 64'h8000_0308, 8'd0, 3'd3, BURST_INCR);
    req.aw_valid = 1'b1;
    #1;
    chk("arb1_b", 64'({resp.b_valid, resp.b.resp, resp.aw_ready}), 64'({1'b1, RESP_OKAY, 1'b0}));
    tick();
    req.b_ready = 1'b0;
    #1;
    chk("arb2_grant", 64'({resp.aw_ready, resp.ar_ready}), 64'b01);
    req.aw_valid = 1'b0;
    do_read("arb2_rd", 4'd4, 64'h8000_0300, 8'd0, BURST_INCR, 1'b0);
    chk("arb2_data", rd_data[0], 64'h55);
    do_write("arb2_wr", 4'd6, 64'h8000_0308, 8'd0, 3'd3, BURST_INCR,
             64'h66, 8'hFF, 0, RESP_OKAY);

    // reset during beat 2 of an 8-beat write
    tick();
    req.aw       = mk_ax(4'd8, 64'h8000_0500, 8'd7, 3'd3, BURST_INCR);
    req.aw_valid = 1'b1;
    #1;
    chk("rstmid_aw_ready", 64'(resp.aw_ready), 64'd1);
    tick();
    req.aw_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req.w_valid = 1'b1;
      req.w.data  = 64'h9000 + 64'(k);
      req.w.strb  = 8'hFF;
      req.w.last  = 1'b0;
      tick();
    end
    req.w.data = 64'h9002;
    rst        = 1'b1;
    tick();
    rst         = 1'b0;
    req.w_valid = 1'b0;
    #1;
    chk("rstmid_quiet", 64'({resp.aw_ready, resp.ar_ready, resp.w_ready,
                             resp.b_valid, resp.r_valid}), 64'd0);
    do_read("rstmid_rd", 4'd9, 64'h8000_0508, 8'd0, BURST_INCR, 1'b0);
    chk("rstmid_data", rd_data[0], 64'h9001);
    chk("rstmid_resp", 64'(rd_resp[0]), 64'(RESP_OKAY));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
